// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-triggered interrupt collector with mask, fixed priority and
// a request/acknowledge/return handshake towards the CPU.
module intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3,
  parameter int CNT_W   = 8
) (
  input  logic               Clk,
  input  logic               Clrn,
  input  logic [NUM_SRC-1:0] IrqIn,
  input  logic               MaskWe,
  input  logic [NUM_SRC-1:0] MaskIn,
  input  logic               Inta,
  input  logic               Eret,
  output logic               Intr,
  output logic [ID_W-1:0]    IntId,
  output logic               Busy,
  output logic [NUM_SRC-1:0] Pending,
  output logic [NUM_SRC-1:0] Mask,
  output logic [CNT_W-1:0]   ServCnt
);
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
  state_t             r_state, w_state_n;
  logic [NUM_SRC-1:0] r_irq_q, r_pend, r_mask, w_rise, w_elig, w_clr;
  logic [ID_W-1:0]    r_id, w_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_intr, r_busy, w_ack, w_load;
  assign w_rise = IrqIn & ~r_irq_q;
  assign w_elig = r_pend & r_mask;
  assign w_ack  = (r_state == REQ) && Inta;
  assign w_load = (w_state_n == REQ) && (r_state != REQ);
  // Lowest eligible index wins; the clear vector targets the acknowledged source.
  always_comb begin
    w_sel = '0;
    w_clr = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      w_sel    = w_elig[i] ? ID_W'(i) : w_sel;
      w_clr[i] = w_ack && (r_id == ID_W'(i));
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_state_n = (r_state == IDLE) ? (|w_elig ? REQ : IDLE) :
                (r_state == REQ)  ? (Inta ? SERV : REQ) :
                (Eret ? (|w_elig ? REQ : IDLE) : SERV);
  end
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state <= IDLE;
      r_irq_q <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_intr  <= 1'b0;
      r_busy  <= 1'b0;
      r_id    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_irq_q <= IrqIn;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (MaskWe) r_mask <= MaskIn;
      r_intr  <= (w_state_n == REQ);
      r_busy  <= (w_state_n == SERV);
      if (w_load) r_id <= w_sel;
      if (w_ack && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign Intr    = r_intr;
  assign IntId   = r_id;
  assign Busy    = r_busy;
  assign Pending = r_pend;
  assign Mask    = r_mask;
  assign ServCnt = r_cnt;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed scoreboard bench for intr_ctrl.
module tb_intr_ctrl;
  logic       Clk = 1'b0, Clrn = 1'b0;
  logic [7:0] IrqIn = '0, MaskIn = '0;
  logic       MaskWe = 1'b0, Inta = 1'b0, Eret = 1'b0;
  logic       Intr, Busy;
  logic [2:0] IntId;
  logic [7:0] Pending, Mask, ServCnt;
  int errs = 0, checks = 0;
  typedef struct {string tag; logic [28:0] exp;} item_t;
  item_t sb[$];

  intr_ctrl #(.NUM_SRC(8), .ID_W(3), .CNT_W(8)) dut (
    .Clk(Clk), .Clrn(Clrn), .IrqIn(IrqIn), .MaskWe(MaskWe), .MaskIn(MaskIn),
    .Inta(Inta), .Eret(Eret), .Intr(Intr), .IntId(IntId), .Busy(Busy),
    .Pending(Pending), .Mask(Mask), .ServCnt(ServCnt)
  );

  always #5 Clk = ~Clk;

  task automatic push(input string tag, input logic intr, input logic [2:0] id,
                      input logic busy, input logic [7:0] pend, input logic [7:0] mask,
                      input logic [7:0] cnt);
    item_t it;
    it.tag = tag;
    it.exp = {intr, id, busy, pend, mask, cnt};
    sb.push_back(it);
  endtask

  task automatic compare();
    item_t it;
    logic [28:0] obs;
    it  = sb.pop_front();
    obs = {Intr, IntId, Busy, Pending, Mask, ServCnt};
    checks++;
    assert (obs === it.exp) else begin
      errs++;
      $error("FAIL %s: observed intr=%b id=%0d busy=%b pend=%h mask=%h cnt=%0d expected intr=%b id=%0d busy=%b pend=%h mask=%h cnt=%0d",
             it.tag, obs[28], obs[27:25], obs[24], obs[23:16], obs[15:8], obs[7:0],
             it.exp[28], it.exp[27:25], it.exp[24], it.exp[23:16], it.exp[15:8], it.exp[7:0]);
    end
  endtask

  task automatic step(input string tag, input logic intr, input logic [2:0] id,
                      input logic busy, input logic [7:0] pend, input logic [7:0] mask,
                      input logic [7:0] cnt);
    push(tag, intr, id, busy, pend, mask, cnt);
    @(posedge Clk);
    #1;
    compare();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    push("reset", 0, 0, 0, 8'h00, 8'h00, 0); compare();
    Clrn = 1'b1;
    MaskWe = 1; MaskIn = 8'hFF;
    step("mask_ff", 0, 0, 0, 8'h00, 8'hFF, 0);
    MaskWe = 0;
    IrqIn = 8'h20;
    step("pend5", 0, 0, 0, 8'h20, 8'hFF, 0);
    step("req5", 1, 5, 0, 8'h20, 8'hFF, 0);
    Inta = 1; step("ack5", 0, 5, 1, 8'h00, 8'hFF, 1); Inta = 0;
    Eret = 1; step("eret5", 0, 5, 0, 8'h00, 8'hFF, 1); Eret = 0;
    IrqIn = 8'h64;
    step("pend2_6", 0, 5, 0, 8'h44, 8'hFF, 1);
    step("req2", 1, 2, 0, 8'h44, 8'hFF, 1);
    Inta = 1; step("ack2", 0, 2, 1, 8'h40, 8'hFF, 2); Inta = 0;
    Eret = 1; step("eret_direct6", 1, 6, 0, 8'h40, 8'hFF, 2); Eret = 0;
    Inta = 1; step("ack6", 0, 6, 1, 8'h00, 8'hFF, 3); Inta = 0;
    Eret = 1; step("eret6", 0, 6, 0, 8'h00, 8'hFF, 3); Eret = 0;
    MaskWe = 1; MaskIn = 8'h01; IrqIn = 8'h6C;
    step("masked_pend3", 0, 6, 0, 8'h08, 8'h01, 3);
    MaskWe = 0;
    step("masked_hold", 0, 6, 0, 8'h08, 8'h01, 3);
    MaskWe = 1; MaskIn = 8'h08;
    step("unmask_edge", 0, 6, 0, 8'h08, 8'h08, 3);
    MaskWe = 0;
    step("req3", 1, 3, 0, 8'h08, 8'h08, 3);
    Inta = 1; step("ack3", 0, 3, 1, 8'h00, 8'h08, 4); Inta = 0;
    Eret = 1; step("eret3", 0, 3, 0, 8'h00, 8'h08, 4); Eret = 0;
    MaskWe = 1; MaskIn = 8'hFF;
    step("mask_ff2", 0, 3, 0, 8'h00, 8'hFF, 4);
    MaskWe = 0;
    IrqIn = 8'h7C;
    step("pend4", 0, 3, 0, 8'h10, 8'hFF, 4);
    step("req4", 1, 4, 0, 8'h10, 8'hFF, 4);
    Inta = 1; step("ack4", 0, 4, 1, 8'h00, 8'hFF, 5); Inta = 0;
    IrqIn = 8'h6C;
    step("serv_low", 0, 4, 1, 8'h00, 8'hFF, 5);
    IrqIn = 8'h7C;
    step("serv_relatch", 0, 4, 1, 8'h10, 8'hFF, 5);
    Eret = 1; step("eret_req4", 1, 4, 0, 8'h10, 8'hFF, 5); Eret = 0;
    step("req4_hold", 1, 4, 0, 8'h10, 8'hFF, 5);
    IrqIn = 8'h6C;
    step("req4_low", 1, 4, 0, 8'h10, 8'hFF, 5);
    IrqIn = 8'h7C; Inta = 1;
    step("set_wins", 0, 4, 1, 8'h10, 8'hFF, 6);
    Inta = 0;
    Eret = 1; step("eret_req4b", 1, 4, 0, 8'h10, 8'hFF, 6); Eret = 0;
    Inta = 1; step("ack4b", 0, 4, 1, 8'h00, 8'hFF, 7); Inta = 0;
    Eret = 1; step("eret4b", 0, 4, 0, 8'h00, 8'hFF, 7); Eret = 0;
    step("level_no_retrig", 0, 4, 0, 8'h00, 8'hFF, 7);
    IrqIn = 8'h6C;
    step("drop4", 0, 4, 0, 8'h00, 8'hFF, 7);
    IrqIn = 8'h7C;
    step("pend4c", 0, 4, 0, 8'h10, 8'hFF, 7);
    step("req4c", 1, 4, 0, 8'h10, 8'hFF, 7);
    #2; Clrn = 1'b0; IrqIn = 8'h00;
    #1;
    push("async_reset", 0, 0, 0, 8'h00, 8'h00, 0); compare();
    #3; Clrn = 1'b1;
    Inta = 1; step("stray_inta", 0, 0, 0, 8'h00, 8'h00, 0); Inta = 0;
    Eret = 1; step("stray_eret", 0, 0, 0, 8'h00, 8'h00, 0); Eret = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
